mix_columns_iter: RTL

Iterative AES MixColumns engine. It accepts a 128-bit cipher state over a valid/ready handshake and transforms CYCLE_COLS columns per clock through a shared column mixer. It returns the mixed state over a second valid/ready handshake. The block sits between ShiftRows and AddRoundKey in the round datapath and trades area for latency relative to a fully parallel MixColumns.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/mix_single_column.sv | 45 ++++
 rtl/mix_columns_iter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, reduction polynomial, xtime and the
// MixColumns FSM state type.
package aes_pkg;

  localparam int         BLOCK_W  = 128;
  localparam int         COL_W    = 32;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Multiply by x in GF(2^8), reducing modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (row r = bits [8r+7:8r]).
// MIX_COLUMNS_INV_EN adds the inv input and the InvMixColumns multipliers.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col,
`ifdef MIX_COLUMNS_INV_EN
  input  logic             inv,
`endif
  output logic [COL_W-1:0] mixed
);

  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x3  [4];
  logic [7:0] fwd [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    assign a[r]   = col[8*r +: 8];
    assign x2[r]  = xtime(a[r]);
    assign x3[r]  = x2[r] ^ a[r];
    assign fwd[r] = x2[r] ^ x3[R1] ^ a[R2] ^ a[R3];

`ifdef MIX_COLUMNS_INV_EN
    // Row r of the inverse matrix: 0E 0B 0D 09 starting at column r.
    logic [7:0] x4, x8, m9, mb, md, me;
    logic [7:0] rev;
    assign x4  = xtime(x2[r]);
    assign x8  = xtime(x4);
    assign me  = x8 ^ x4 ^ x2[r];
    assign mb  = xtime(xtime(xtime(a[R1]))) ^ x2[R1] ^ a[R1];
    assign md  = xtime(xtime(xtime(a[R2]))) ^ xtime(x2[R2]) ^ a[R2];
    assign m9  = xtime(xtime(xtime(a[R3]))) ^ a[R3];
    assign rev = me ^ mb ^ md ^ m9;
    assign mixed[8*r +: 8] = inv ? rev : fwd[r];
`else
    assign mixed[8*r +: 8] = fwd[r];
`endif
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: CYCLE_COLS columns per clock through shared mixers.
// MIX_COLUMNS_INV_EN adds the inv port selecting InvMixColumns per block.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int CYCLE_COLS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] data_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic               inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               busy
);

  localparam int         N    = 4 / CYCLE_COLS;
  localparam logic [1:0] LAST = 2'(N - 1);

  state_t               state, state_next;
  logic [1:0]           col_idx;
  logic [1:0]           base;
  logic [BLOCK_W-1:0]   work, work_next;
  logic                 accept, last;
  logic [1:0]           col_sel [CYCLE_COLS];
  logic [COL_W-1:0]     mix_in  [CYCLE_COLS];
  logic [COL_W-1:0]     mix_out [CYCLE_COLS];
`ifdef MIX_COLUMNS_INV_EN
  logic                 inv_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign last   = (col_idx == LAST);
  assign base   = 2'(col_idx * CYCLE_COLS);

  // One mixer per column slot; col_idx selects which group of columns feeds them.
  for (genvar g = 0; g < CYCLE_COLS; g++) begin : g_mix
    assign col_sel[g] = base + 2'(g);
    assign mix_in[g]  = work[{col_sel[g], 5'b0} +: COL_W];

    mix_single_column u_mix (
      .col   (mix_in[g]),
`ifdef MIX_COLUMNS_INV_EN
      .inv   (inv_q),
`endif
      .mixed (mix_out[g])
    );
  end

  always_comb begin
    work_next = work;
    for (int g = 0; g < CYCLE_COLS; g++) begin
      work_next[{col_sel[g], 5'b0} +: COL_W] = mix_out[g];
    end
  end

  // Columns are mixed in place; data_out only loads on the final group so it
  // holds the previous result until the next block completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      col_idx   <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work    <= data_in;
            col_idx <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= inv;
`endif
          end
        end
        RUN: begin
          work <= work_next;
          if (last) begin
            data_out  <= work_next;
            out_valid <= 1'b1;
          end else begin
            col_idx <= col_idx + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
